// File: rtl/wiegand26_tx.sv
// wiegand26_tx: serialises one 26-bit Wiegand frame onto the D0/D1 lines.
// Frame bit 25 goes out first. Each bit is a PULSE_CYC-cycle low pulse on D0 ('0')
// or D1 ('1'), and PERIOD_CYC cycles separate successive pulse starts.
// int_n goes low for exactly one cycle after a completed frame. Dropping en aborts
// a frame silently, and no interrupt is raised.
module wiegand26_tx #(
    parameter int unsigned PULSE_CYC  = 1000,
    parameter int unsigned PERIOD_CYC = 20000,
    parameter bit          PARITY_GEN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [25:0] data,
    output logic        busy,
    output logic        d0,
    output logic        d1,
    output logic        int_n
);

    localparam int unsigned TW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(PERIOD_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [4:0]    r_bitcnt;
    logic [25:0]   r_frame;
    logic          r_busy;
    logic          r_d0;
    logic          r_d1;
    logic          r_int_n;
    logic [25:0]   w_frame;

    // Frame to latch on start, with optional even/odd parity regeneration
    always_comb begin
        w_frame = data;
        if (PARITY_GEN) begin
            w_frame[25] = ^data[24:13];
            w_frame[0]  = ~(^data[12:1]);
        end
    end

    // Bit sequencer: every output is registered, so each line is driven one edge ahead.
    // The frame shifts at the PULSE->GAP boundary, not at the end of GAP, so that
    // r_frame[25] already holds the next bit when its pulse has to be launched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bitcnt <= 5'd25;
            r_frame  <= '0;
            r_busy   <= 1'b0;
            r_d0     <= 1'b1;
            r_d1     <= 1'b1;
            r_int_n  <= 1'b1;
        end else if (!en) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bitcnt <= 5'd25;
            r_busy   <= 1'b0;
            r_d0     <= 1'b1;
            r_d1     <= 1'b1;
            r_int_n  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_int_n <= 1'b1;
                    if (start) begin
                        r_frame  <= w_frame;
                        r_bitcnt <= 5'd25;
                        r_timer  <= '0;
                        r_busy   <= 1'b1;
                        r_d0     <= w_frame[25];
                        r_d1     <= ~w_frame[25];
                        r_state  <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    r_timer <= r_timer + 1'b1;
                    if (r_timer == PULSE_LAST) begin
                        r_d0    <= 1'b1;
                        r_d1    <= 1'b1;
                        r_frame <= {r_frame[24:0], 1'b0};
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_timer == PERIOD_LAST) begin
                        r_timer <= '0;
                        if (r_bitcnt != 5'd0) begin
                            r_bitcnt <= r_bitcnt - 5'd1;
                            r_d0     <= r_frame[25];
                            r_d1     <= ~r_frame[25];
                            r_state  <= S_PULSE;
                        end else begin
                            r_int_n <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    r_int_n  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_bitcnt <= 5'd25;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign d0    = r_d0;
    assign d1    = r_d1;
    assign int_n = r_int_n;

endmodule

// File: doc/wiegand26_tx.md
Name: wiegand26_tx

Overview:
- Serialises one 26-bit Wiegand frame onto the two-wire D0/D1 output toward the external access-control panel.
- Sits downstream of the bus-interface register that the host CPU writes (4 byte writes assemble 26 bits), gated by the Wiegand-output enable bit.
- Signals frame completion with an active-low interrupt pulse that the interface latches into its status/configure bit.
- Optionally regenerates the two parity bits in hardware.

Parameters:
PULSE_CYC, 1000, low-pulse width per bit in clk cycles (100 us at 10 MHz); must be >= 1
PERIOD_CYC, 20000, bit period in clk cycles from pulse start to next pulse start; must be > PULSE_CYC
PARITY_GEN, 1, 1 = replace frame[25] and frame[0] with computed parity; 0 = send data[25:0] raw

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
en  input  1  transmitter enable; low forces idle/abort
start  input  1  one-cycle request to send the frame; sampled on rising clk edge
data  input  26  frame; bit 25 is transmitted first
busy  output  1  high while a frame is in progress, including the DONE cycle
d0  output  1  Wiegand DATA0 line; idle high, pulses low for a '0' bit
d1  output  1  Wiegand DATA1 line; idle high, pulses low for a '1' bit
int_n  output  1  active-low completion strobe; exactly one clk cycle low per completed frame

Behaviour:
- Reset (rst low, asynchronous): state IDLE; d0=1, d1=1, int_n=1, busy=0; bit counter=25; timer=0; frame shift register cleared.
- State IDLE:
  - If en=1 and start=1 at a clk edge, latch the frame into the shift register, load bit counter=25 and timer=0, and go to PULSE. busy=1 from the next cycle.
  - start while en=0 is ignored.
- Frame content when PARITY_GEN=1:
  - frame[24:1] = data[24:1]
  - frame[25] = XOR of data[24:13] (even parity)
  - frame[0] = NOT XOR of data[12:1] (odd parity)
- State PULSE:
  - If the current bit = 0, d0=0 and d1=1; if the current bit = 1, d1=0 and d0=1. Both lines are never low together.
  - Lasts PULSE_CYC cycles. The first pulse begins in the cycle after start was sampled (latency 1).
  - Then go to GAP.
- State GAP:
  - d0=1, d1=1 for PERIOD_CYC-PULSE_CYC cycles.
  - At the end: if bit counter > 0, decrement it, shift the frame, and go to PULSE; if bit counter = 0, go to DONE.
- State DONE:
  - int_n=0 and busy=1 for exactly 1 cycle, then IDLE with int_n=1 and busy=0.
  - Total frame time from the start sample to the first IDLE cycle = 26*PERIOD_CYC + 1 cycles.
- Timer: counts 0..PERIOD_CYC-1 within each bit and is wide enough for PERIOD_CYC-1. The PULSE/GAP split is at timer = PULSE_CYC.
- start while busy: ignored. No queueing; data changes while busy have no effect (latched copy is used).
- en falling while busy:
  - Next cycle: state IDLE, d0=d1=1, busy=0.
  - int_n stays high (an aborted frame raises no interrupt).
  - A pulse in progress is truncated.
- start and en rising in the same cycle: accepted.
- start in the DONE cycle: ignored. A new frame may start from the first IDLE cycle.
- Reset mid-frame: immediate return to the reset values, including on the d0/d1 lines.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. PULSE_CYC=4, PERIOD_CYC=10, PARITY_GEN=0, data=26'h2AAAAAA, en=1, start pulse -> expected response:
   - 13 d1 and 13 d0 pulses, alternating, d1 first.
   - Each pulse 4 cycles low with a 6-cycle high gap.
   - int_n low exactly once, 261 cycles after start was sampled.
   - busy high 261 cycles.
2. PARITY_GEN=1, data=26'h0000002 -> expected response:
   - frame=26'h0000002.
   - d0 pulses at bit positions 25..2 and 0; d1 pulses only at the 25th pulse.
   - data=26'h1FFFFFE -> frame[25]=0, frame[0]=1.
3. Second start asserted at cycle 50 of a frame with different data -> expected response:
   - Transmitted bits match the first data only.
   - Single int_n pulse.
   - Next start in the first IDLE cycle sends the new frame.
4. en dropped at cycle 102 (mid-pulse of bit 15) -> expected response:
   - d0=d1=1 and busy=0 by cycle 103.
   - int_n never low.
   - Subsequent start with en=1 sends a full 26-bit frame.
5. rst asserted low asynchronously between clk edges during PULSE -> expected response:
   - d0/d1 go high and busy goes 0 without waiting for clk.
   - After release, start produces a normal frame.
6. start with en=0, then en=1 with no start -> expected response: d0=d1=1, busy=0, int_n=1 for 500 cycles.
